// File: rtl/sseg_scan.sv
// Time-multiplexed seven-segment display driver.
// Scans NUM_DIGITS common-anode digits, decoding one hex nibble per digit. Inputs are staged
// on a load strobe and only transferred to the displayed (active) set at the start of a frame,
// so a frame never mixes old and new data. Each digit slot opens with a short all-off window
// to suppress ghosting while the anode/segment drivers settle.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   value      packed hex nibbles, nibble i = digit i (0 = rightmost)
//   dp_in      decimal point request per digit (1 = lit)
//   digit_en   per-digit enable (0 = digit always blank)
//   lz_blank   suppress leading zeros (digit 0 is never suppressed)
//   load       1-cycle strobe that stages value/dp_in/digit_en/lz_blank
//   seg        {g,f,e,d,c,b,a}, active low
//   dp         decimal point, active low
//   an         anodes, active low
//   frame      1-cycle pulse when the slot of digit 0 begins
module sseg_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PreW-1:0] LastPre  = PreW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_DIGITS - 1);
  localparam logic [PreW-1:0] BlankEnd = PreW'(BLANK_CYC);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [PreW-1:0]         pre_q, pre_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_stg_q, val_stg_d, val_act_q, val_act_d;
  logic [NUM_DIGITS-1:0]   dp_stg_q, dp_stg_d, dp_act_q, dp_act_d;
  logic [NUM_DIGITS-1:0]   en_stg_q, en_stg_d, en_act_q, en_act_d;
  logic                    lz_stg_q, lz_stg_d, lz_act_q, lz_act_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic       wrap, frame_wrap;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_en, lz_hide, zero_above, lit;

  always_comb begin
    wrap       = (pre_q == LastPre);
    frame_wrap = wrap && (idx_q == LastIdx);
    pre_d      = wrap ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    if (wrap) idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

    val_stg_d = val_stg_q;
    dp_stg_d  = dp_stg_q;
    en_stg_d  = en_stg_q;
    lz_stg_d  = lz_stg_q;
    if (load) begin
      val_stg_d = value;
      dp_stg_d  = dp_in;
      en_stg_d  = digit_en;
      lz_stg_d  = lz_blank;
    end

    // Active set follows staging only on the frame edge; a load on that same edge lands in
    // staging and waits for the next frame.
    val_act_d = val_act_q;
    dp_act_d  = dp_act_q;
    en_act_d  = en_act_q;
    lz_act_d  = lz_act_q;
    if (frame_wrap) begin
      val_act_d = val_stg_q;
      dp_act_d  = dp_stg_q;
      en_act_d  = en_stg_q;
      lz_act_d  = lz_stg_q;
    end

    // Select the current digit and decide leading-zero suppression by walking from the top
    // digit down: a digit is suppressed if it and all digits above it are zero.
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    lz_hide    = 1'b0;
    zero_above = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (val_act_q[4*i +: 4] == 4'h0);
      if (idx_q == IdxW'(i)) begin
        cur_nib = val_act_q[4*i +: 4];
        cur_dp  = dp_act_q[i];
        cur_en  = en_act_q[i];
        lz_hide = lz_act_q && zero_above && (i != 0);
      end
    end
    lit = cur_en && !lz_hide;

    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    an_d    = '1;
    frame_d = frame_wrap;
    if ((pre_q >= BlankEnd) && lit) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      val_stg_q <= '0;
      dp_stg_q  <= '0;
      en_stg_q  <= '0;
      lz_stg_q  <= 1'b0;
      val_act_q <= '0;
      dp_act_q  <= '0;
      en_act_q  <= '0;
      lz_act_q  <= 1'b0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      val_stg_q <= val_stg_d;
      dp_stg_q  <= dp_stg_d;
      en_stg_q  <= en_stg_d;
      lz_stg_q  <= lz_stg_d;
      val_act_q <= val_act_d;
      dp_act_q  <= dp_act_d;
      en_act_q  <= en_act_d;
      lz_act_q  <= lz_act_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
// Outputs are sampled 1 time unit after each rising edge. After a frame pulse sampled at edge F,
// edge F+j (j=1..32) shows digit (j-1)/8 at slot position (j-1)%8.
module tb_sseg_scan;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en;
  logic        lz_blank, load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sseg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d,
                         input logic lz);
    value = v; digit_en = e; dp_in = d; lz_blank = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Steps until a frame pulse is seen or the bound expires; callers check frame afterwards.
  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (frame !== 1'b1 && cycles < 100);
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1; value = '0; dp_in = '0; digit_en = '0; lz_blank = 1'b0; load = 1'b0;
    #1;
    n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %h exp f", an); end
    n_chk++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h exp 7f", seg); end
    n_chk++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b exp 1", dp); end
    n_chk++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b exp 0", frame); end
    step(); step();
    rst = 1'b0;
    wait_frame(cyc);
    n_chk++;
    if (frame !== 1'b1 || cyc != 32) begin
      n_fail++; $display("FAIL reset_first_frame cycles=%0d exp 32", cyc);
    end
    // Nothing loaded: every digit disabled for the whole frame.
    for (int j = 1; j <= 32; j++) begin
      step();
      n_chk++;
      if (an !== 4'hF || dp !== 1'b1) begin
        n_fail++; $display("FAIL reset_dark j=%0d an=%h dp=%b exp f 1", j, an, dp);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] tab [4];
    logic [3:0] ea;
    logic [6:0] es;
    int cyc, d, p;
    tab[0] = 7'h19; tab[1] = 7'h46; tab[2] = 7'h24; tab[3] = 7'h79;
    do_load(16'h12C4, 4'hF, 4'h0, 1'b0);
    wait_frame(cyc);
    n_chk++; if (frame !== 1'b1) begin n_fail++; $display("FAIL basic_frame timeout"); end
    for (int j = 1; j <= 32; j++) begin
      d = (j - 1) / 8; p = (j - 1) % 8;
      step();
      ea = (p < BC) ? 4'hF : ~(4'b0001 << d);
      es = (p < BC) ? 7'h7F : tab[d];
      n_chk++;
      if (an !== ea || seg !== es || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL basic j=%0d an=%h seg=%h dp=%b exp %h %h 1", j, an, seg, dp, ea, es);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] tab [4];
    logic [3:0] lit, ea;
    int cyc, d, p;
    tab[0] = 7'h40; tab[1] = 7'h08; tab[2] = 7'h7F; tab[3] = 7'h7F;
    lit = 4'b0011;
    do_load(16'h00A0, 4'hF, 4'h0, 1'b1);
    wait_frame(cyc);
    n_chk++; if (frame !== 1'b1) begin n_fail++; $display("FAIL lz_frame timeout"); end
    for (int j = 1; j <= 32; j++) begin
      d = (j - 1) / 8; p = (j - 1) % 8;
      step();
      ea = (p < BC || !lit[d]) ? 4'hF : ~(4'b0001 << d);
      n_chk++;
      if (an !== ea || dp !== 1'b1) begin
        n_fail++; $display("FAIL lz_an j=%0d an=%h dp=%b exp %h 1", j, an, dp, ea);
      end
      if (p >= BC && lit[d]) begin
        n_chk++;
        if (seg !== tab[d]) begin
          n_fail++; $display("FAIL lz_seg j=%0d seg=%h exp %h", j, seg, tab[d]);
        end
      end
    end
  endtask

  task automatic test_enable_dp();
    logic [6:0] tab [4];
    logic [3:0] lit, ea;
    logic       ed;
    int cyc, d, p;
    tab[0] = 7'h12; tab[1] = 7'h02; tab[2] = 7'h78; tab[3] = 7'h00;
    lit = 4'b1011;
    // dp requested on digit 0 (enabled) and digit 2 (disabled).
    do_load(16'h8765, 4'b1011, 4'b0101, 1'b0);
    wait_frame(cyc);
    n_chk++; if (frame !== 1'b1) begin n_fail++; $display("FAIL en_frame timeout"); end
    for (int j = 1; j <= 32; j++) begin
      d = (j - 1) / 8; p = (j - 1) % 8;
      step();
      ea = (p < BC || !lit[d]) ? 4'hF : ~(4'b0001 << d);
      ed = (p >= BC && d == 0) ? 1'b0 : 1'b1;
      n_chk++;
      if (an !== ea || dp !== ed) begin
        n_fail++; $display("FAIL en_dp j=%0d an=%h dp=%b exp %h %b", j, an, dp, ea, ed);
      end
      if (p >= BC && lit[d]) begin
        n_chk++;
        if (seg !== tab[d]) begin
          n_fail++; $display("FAIL en_seg j=%0d seg=%h exp %h", j, seg, tab[d]);
        end
      end
    end
  endtask

  task automatic test_tear();
    logic [6:0] es;
    int cyc;
    do_load(16'h1111, 4'hF, 4'h0, 1'b0);
    wait_frame(cyc);
    n_chk++; if (frame !== 1'b1) begin n_fail++; $display("FAIL tear_frame timeout"); end
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 32; j++) begin
        if (f == 0 && j == 10) begin
          value = 16'h2222; load = 1'b1;
        end
        step();
        load = 1'b0;
        es = ((j - 1) % 8 < BC) ? 7'h7F : ((f == 0) ? 7'h79 : 7'h24);
        n_chk++;
        if (seg !== es) begin
          n_fail++; $display("FAIL tear f=%0d j=%0d seg=%h exp %h", f, j, seg, es);
        end
      end
      n_chk++;
      if (frame !== 1'b1) begin n_fail++; $display("FAIL tear_period f=%0d frame=0 exp 1", f); end
    end
  endtask

  // Continues from the frame pulse that ends test_tear; load of 3333 coincides with the next one.
  task automatic test_load_on_frame();
    logic [6:0] es;
    logic       ef;
    for (int f = 0; f < 3; f++) begin
      for (int j = 1; j <= 32; j++) begin
        if (f == 0 && j == 32) begin
          value = 16'h3333; load = 1'b1;
        end
        step();
        load = 1'b0;
        es = ((j - 1) % 8 < BC) ? 7'h7F : ((f < 2) ? 7'h24 : 7'h30);
        ef = (j == 32);
        n_chk++;
        if (seg !== es || frame !== ef) begin
          n_fail++;
          $display("FAIL load_on_frame f=%0d j=%0d seg=%h frame=%b exp %h %b", f, j, seg, frame,
                   es, ef);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    do_load(16'h12C4, 4'hF, 4'h0, 1'b0);
    wait_frame(cyc);
    for (int j = 1; j <= 12; j++) step();
    n_chk++;
    if (an !== 4'b1101 || seg !== 7'h46) begin
      n_fail++; $display("FAIL mid_lit an=%h seg=%h exp d 46", an, seg);
    end
    do_load(16'h5555, 4'hF, 4'hF, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset an=%h seg=%h dp=%b frame=%b exp f 7f 1 0", an, seg, dp, frame);
    end
    step(); step();
    rst = 1'b0;
    wait_frame(cyc);
    n_chk++;
    if (frame !== 1'b1 || cyc != 32) begin
      n_fail++; $display("FAIL mid_restart cycles=%0d exp 32", cyc);
    end
    // Pending load was cleared by reset, so the frame stays dark.
    for (int j = 1; j <= 32; j++) begin
      step();
      n_chk++;
      if (an !== 4'hF || dp !== 1'b1) begin
        n_fail++; $display("FAIL mid_lost_load j=%0d an=%h dp=%b exp f 1", j, an, dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_enable_dp();
    test_tear();
    test_load_on_frame();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
